uart_rx_deser: RTL and testbench
================================

Name: uart_rx_deser

Overview:
UART receive deserializer for the UART physical layer. It takes the serial `rx` line from the pad or link and oversamples it with the system clock. It recovers 8N1-plus-parity frames (start, 8 data bits LSB first, parity, stop) and presents each received byte on `data_out`, with a one-cycle `data_ready` pulse and per-frame error flags. It is the receive counterpart of the UART transmit path and shares the same serial format.

Parameters:
- CLK_DIV, 16, clk cycles per bit period; legal values are even and >= 4.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_en  input  1  receiver enable; low aborts any frame in progress and holds the block idle.
- rx  input  1  serial line, asynchronous to clk, idle high.
- data_out  output  8  last received byte.
- data_ready  output  1  one-cycle pulse when a frame completes.
- parity_error  output  1  parity mismatch on the last completed frame.
- stop_error  output  1  stop bit sampled low on the last completed frame.

Behaviour:
- Reset: clears `data_out`, `data_ready`, `parity_error` and `stop_error` to 0. The FSM goes to IDLE, the bit counter to 0, and the `rx` synchronizer flops to 1.
- Synchronizer: `rx` passes through a 2-flop synchronizer; all logic uses the synchronized value `rx_s`.
- Bit timer: counter `cnt` runs 0..CLK_DIV-1.
  - Cleared on the IDLE-to-START transition.
  - In START, the sample point is `cnt == CLK_DIV/2-1`; the counter clears there.
  - In all later states, the sample point is `cnt == CLK_DIV-1`, which is mid-bit; the counter clears there.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE -> START when `rx_en` = 1 and `rx_s` falls (1 then 0).
  - START at its sample point: `rx_s` = 0 -> DATA with bit index 0; `rx_s` = 1 -> IDLE (glitch or false start, no output).
  - DATA: at each sample point, shift `rx_s` into the MSB of the shift register (LSB-first reception). After bit index 7 -> PARITY.
  - PARITY: sample the parity bit. The expected value is the XOR of the 8 data bits, inverted when PARITY_ODD = 1. -> STOP.
  - STOP: sample the stop bit. On the next clk:
    - `data_out` <= shift register and `data_ready` <= 1 for exactly one cycle.
    - `parity_error` <= mismatch and `stop_error` <= (stop sample == 0).
    - Next state is IDLE if the stop sample was 1, otherwise BREAK.
  - BREAK: wait until `rx_s` == 1, then -> IDLE. This blocks framing off the middle of a break.
- Error flags are delivered with the frame's `data_ready` and hold until the next completed frame overwrites them.
- A byte with errors is still delivered with `data_ready` = 1.
- Latency: `data_ready` rises CLK_DIV/2 + 10*CLK_DIV + 1 clk after the synchronized falling edge. This is 169 cycles at CLK_DIV = 16, plus 2 cycles of synchronizer delay.
- `rx_en` deassertion mid-frame: synchronous return to IDLE on the next clk.
  - No `data_ready` pulse; `data_out` and the error flags are unchanged.
  - Re-enabling while `rx` is low does not start a frame; a new falling edge is required.
- Back-to-back frames: a start edge in the cycle after the STOP sample is accepted. IDLE checks for the edge every cycle, using the previous `rx_s` value held in a register.
- Asynchronous reset mid-frame: immediate return to reset values; the partial frame is discarded.

Optional Feature:
Macro `UART_RX_MAJORITY_EN`.
- Defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of `rx_s` at the sample point, the cycle before it and the cycle after it. The decision registers one cycle after the centre sample; overall latency increases by 1 clk.
- Undefined: single sample at the sample point; latency as stated in Behaviour.

Decomposition:
- Package `uart_pkg` holds:
  - the `uart_rx_state_t` enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the constant `UART_DATA_BITS` = 8;
  - the function `uart_parity(data, odd)`, shared with the transmit path.
- Sub-module `uart_bit_timer` wraps the CLK_DIV counter. It has inputs `clear` and `half` (first-period mode) and output `sample_tick`, and can be reused by the transmitter.

Test Plan:
- Frame 0xA5 with correct even parity (0), stop = 1, CLK_DIV = 16 -> `data_out` = 0xA5, a single `data_ready` pulse 169 clk after the synchronized edge, both error flags 0.
- Frame 0x3C with parity bit forced to 1 -> `data_out` = 0x3C, `data_ready` pulse, `parity_error` = 1, `stop_error` = 0. A following good frame 0x00 clears `parity_error`.
- Frame 0x81 with stop bit 0, then `rx` held low 40 bit periods -> `stop_error` = 1, `data_ready` pulses once. The FSM stays in BREAK and no second frame is reported until `rx` returns high.
- Low pulse of 5 clk on an idle line -> false start is rejected, no `data_ready`, outputs unchanged.
- `rx_en` dropped during data bit 4 of frame 0x55 -> no `data_ready`. Re-enable with `rx` high and send 0x66 -> `data_out` = 0x66.
- Two back-to-back frames 0x12 and 0x34 with no idle gap -> two `data_ready` pulses 11*CLK_DIV apart with the correct bytes. Repeat with `UART_RX_MAJORITY_EN` defined and a single-cycle glitch at a mid-bit point -> bytes still correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the parity
// helper used by both the receive and transmit paths.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_rx_state_t;

   // Returns the parity bit a transmitter would send for this byte.
   function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                        input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clk cycles and flags the sample point, either
// half a period after a clear (start bit centring) or a full period.
module uart_bit_timer #(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic half,
   output logic sample_tick
);

   localparam int CW = $clog2(CLK_DIV);

   logic [CW-1:0] cnt;

   // Sample point decode for half-period or full-period mode.
   always_comb begin
      if (half) begin
         sample_tick = (cnt == CW'(CLK_DIV / 2 - 1));
      end else begin
         sample_tick = (cnt == CW'(CLK_DIV - 1));
      end
   end

   // Counter restarts at every sample point so bit centres stay aligned.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear || sample_tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer (start, 8 data LSB first, parity, stop).
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
module uart_rx_deser
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_en,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_ready,
   output logic       parity_error,
   output logic       stop_error
);

   localparam logic ODD = (PARITY_ODD != 0);

   uart_rx_state_t state, state_next;

   logic                      rx_meta, rx_s, rx_prev;
   logic [2:0]                bit_idx;
   logic [UART_DATA_BITS-1:0] shreg;
   logic                      par_err_cap;
   logic                      timer_clear, timer_half, sample_tick;
   logic                      bit_tick, bit_val;

   // Two-flop synchronizer plus one history stage for falling-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign timer_clear = (state == IDLE) || (state == BREAK);
   assign timer_half  = (state == START);

   uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk         (clk),
      .reset       (reset),
      .clear       (timer_clear),
      .half        (timer_half),
      .sample_tick (sample_tick)
   );

`ifdef UART_RX_MAJORITY_EN
   logic rx_d2;
   logic tick_d;

   // Decision is taken one cycle after the centre so the following sample exists.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_d2  <= 1'b1;
         tick_d <= 1'b0;
      end else begin
         rx_d2  <= rx_prev;
         tick_d <= sample_tick && !timer_clear;
      end
   end

   assign bit_tick = tick_d;
   assign bit_val  = (rx_s & rx_prev) | (rx_s & rx_d2) | (rx_prev & rx_d2);
`else
   assign bit_tick = sample_tick;
   assign bit_val  = rx_s;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; disabling the receiver overrides everything.
   always_comb begin
      state_next = state;
      if (!rx_en) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (rx_prev && !rx_s) state_next = START;
               else                  state_next = IDLE;
            end
            START: begin
               if (bit_tick) state_next = bit_val ? IDLE : DATA;
               else          state_next = START;
            end
            DATA: begin
               if (bit_tick && (bit_idx == 3'd7)) state_next = PARITY;
               else                               state_next = DATA;
            end
            PARITY: begin
               if (bit_tick) state_next = STOP;
               else          state_next = PARITY;
            end
            STOP: begin
               if (bit_tick) state_next = bit_val ? IDLE : BREAK;
               else          state_next = STOP;
            end
            BREAK: begin
               if (rx_s) state_next = IDLE;
               else      state_next = BREAK;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Datapath: shift in data, capture parity check, publish on the stop sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_idx      <= 3'd0;
         shreg        <= '0;
         par_err_cap  <= 1'b0;
         data_out     <= 8'h00;
         data_ready   <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
      end else begin
         data_ready <= 1'b0;
         if (rx_en) begin
            case (state)
               START: bit_idx <= 3'd0;
               DATA: begin
                  if (bit_tick) begin
                     shreg   <= {bit_val, shreg[UART_DATA_BITS-1:1]};
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
               PARITY: begin
                  if (bit_tick) par_err_cap <= (bit_val != uart_parity(shreg, ODD));
               end
               STOP: begin
                  if (bit_tick) begin
                     data_out     <= shreg;
                     data_ready   <= 1'b1;
                     parity_error <= par_err_cap;
                     stop_error   <= ~bit_val;
                  end
               end
               default: bit_idx <= bit_idx;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Scoreboard bench for uart_rx_deser: frames are driven bit-serially, expected
// bytes/flags/arrival cycles are queued at stimulus time and popped on data_ready.
module tb_uart_rx_deser;

   localparam int CLK_DIV = 16;
`ifdef UART_RX_MAJORITY_EN
   localparam int LAT    = 172;
   localparam int GLITCH = 4;
`else
   localparam int LAT    = 171;
   localparam int GLITCH = -1;
`endif

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       se;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, rx_en, rx;
   logic [7:0] data_out;
   logic       data_ready, parity_error, stop_error;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   ready_cnt = 0;
   int   base_cnt;
   logic ready_prev = 1'b0;
   exp_t sb_q[$];

   uart_rx_deser #(.CLK_DIV(CLK_DIV), .PARITY_ODD(0)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_en        (rx_en),
      .rx           (rx),
      .data_out     (data_out),
      .data_ready   (data_ready),
      .parity_error (parity_error),
      .stop_error   (stop_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Drive one frame starting at a negedge; abort_bit >= 0 drops rx_en mid-bit.
   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit,
                             input int glitch_bit, input int abort_bit);
      logic [10:0] bits;
      exp_t        e;
      bits = {stop_bit, (^d) ^ par_flip, d, 1'b0};
      if (abort_bit < 0) begin
         e.d   = d;
         e.pe  = par_flip;
         e.se  = ~stop_bit;
         e.cyc = cyc + LAT;
         sb_q.push_back(e);
      end
      for (int b = 0; b < 11; b++) begin
         for (int c = 0; c < CLK_DIV; c++) begin
            if (b == abort_bit && c == CLK_DIV / 2) begin
               rx_en = 1'b0;
               rx    = 1'b1;
               repeat (4) @(negedge clk);
               rx_en = 1'b1;
               repeat (CLK_DIV) @(negedge clk);
               return;
            end
            rx = (b == glitch_bit && c == CLK_DIV / 2) ? ~bits[b] : bits[b];
            @(negedge clk);
         end
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && data_ready) begin
         ready_cnt <= ready_cnt + 1;
         check("ready_width", {31'd0, ready_prev}, 32'd0);
         if (sb_q.size() == 0) begin
            check("unexpected_ready", {31'd0, data_ready}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("data_out", {24'd0, data_out}, {24'd0, e.d});
            check("parity_error", {31'd0, parity_error}, {31'd0, e.pe});
            check("stop_error", {31'd0, stop_error}, {31'd0, e.se});
            check("latency", cyc, e.cyc);
         end
      end
      ready_prev <= data_ready;
   end

   initial begin
      reset = 1'b1;
      rx    = 1'b1;
      rx_en = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data_out", {24'd0, data_out}, 32'd0);
      check("rst_data_ready", {31'd0, data_ready}, 32'd0);
      check("rst_parity_error", {31'd0, parity_error}, 32'd0);
      check("rst_stop_error", {31'd0, stop_error}, 32'd0);
      reset = 1'b0;
      rx_en = 1'b1;
      repeat (5) @(negedge clk);

      send_frame(8'hA5, 1'b0, 1'b1, -1, -1);
      repeat (CLK_DIV) @(negedge clk);

      send_frame(8'h3C, 1'b1, 1'b1, -1, -1);
      repeat (2 * CLK_DIV) @(negedge clk);
      check("perr_hold", {31'd0, parity_error}, 32'd1);
      send_frame(8'h00, 1'b0, 1'b1, -1, -1);
      repeat (CLK_DIV) @(negedge clk);
      check("perr_cleared", {31'd0, parity_error}, 32'd0);

      // Stop bit low followed by a long break.
      base_cnt = ready_cnt;
      send_frame(8'h81, 1'b0, 1'b0, -1, -1);
      rx = 1'b0;
      repeat (40 * CLK_DIV) @(negedge clk);
      check("break_single", ready_cnt, base_cnt + 1);
      check("break_stop_err", {31'd0, stop_error}, 32'd1);
      rx = 1'b1;
      repeat (2 * CLK_DIV) @(negedge clk);
      check("break_exit", ready_cnt, base_cnt + 1);

      // Short low pulse must be rejected as a false start.
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CLK_DIV) @(negedge clk);
      check("false_start_cnt", ready_cnt, base_cnt + 1);
      check("false_start_data", {24'd0, data_out}, 32'h81);

      // Receiver disabled during data bit 4.
      send_frame(8'h55, 1'b0, 1'b1, -1, 5);
      repeat (2 * CLK_DIV) @(negedge clk);
      check("abort_cnt", ready_cnt, base_cnt + 1);
      check("abort_data", {24'd0, data_out}, 32'h81);
      check("abort_stop_err", {31'd0, stop_error}, 32'd1);
      send_frame(8'h66, 1'b0, 1'b1, -1, -1);
      repeat (CLK_DIV) @(negedge clk);

      // Back-to-back frames, no idle gap between stop and next start.
      send_frame(8'h12, 1'b0, 1'b1, GLITCH, -1);
      send_frame(8'h34, 1'b0, 1'b1, GLITCH, -1);

      for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
      check("drain", sb_q.size(), 32'd0);
      check("total_frames", ready_cnt, 32'd7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
